// File: rtl/ecc_mont_pkg.sv
// Shared definitions for the Montgomery result collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: collector FSM state encoding and default word geometry
// (32-bit words, 12 words = 384-bit prime field).
package ecc_mont_pkg;

   localparam int RADIX_DEF     = 32;
   localparam int NUM_WORDS_DEF = 12;

   // Collector control states. ST_ZERO is only reachable when the
   // buffer-zeroize build option is enabled.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_DECIDE  = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_ZERO    = 3'd4
   } coll_state_t;

endpackage

// File: rtl/word_sub_borrow.sv
// One word of a ripple subtract: {o_bout, o_d} = i_a - i_b - i_bin.
// Latency: combinational.
// Backpressure: none (pure function).
//
// Ports: i_a minuend word, i_b subtrahend word, i_bin borrow in,
//        o_d difference word (mod 2^RADIX), o_bout borrow out.
module word_sub_borrow #(
   parameter int RADIX = 32
) (
   input  logic [RADIX-1:0] i_a,
   input  logic [RADIX-1:0] i_b,
   input  logic             i_bin,
   output logic [RADIX-1:0] o_d,
   output logic             o_bout
);

   // One extra bit holds the sign of the result; it is set exactly when
   // a < b + bin, which is the borrow out.
   logic [RADIX:0] w_full;

   assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{RADIX{1'b0}}, i_bin};
   assign o_d    = w_full[RADIX-1:0];
   assign o_bout = w_full[RADIX];

endmodule

// File: rtl/mont_result_collector.sv
// Collects word-serial Montgomery result S and emits S mod p (one conditional subtract of p).
// Latency: first output word valid 2 cycles after the last input word is accepted; 1 word/cycle each side.
// Backpressure: s_ready_o low from end of collect until back in IDLE; output word held while r_ready_i=0.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   p_i                   modulus, LSW in bits [RADIX-1:0]; stable while busy_o=1
//   s_valid_i/s_ready_o   input word handshake; s_word_i LSW first,
//   s_last_i, s_carry_i   s_last_i marks word NUM_WORDS-1, s_carry_i sampled with it
//   r_valid_o/r_ready_i   output word handshake; r_word_o LSW first, r_last_o on final word
//   busy_o                operand in progress
//   err_o                 sticky framing error (s_last_i disagreed with word count)
// Build option: MONT_COLLECT_ZEROIZE_EN adds a ZERO state after DRAIN that wipes
// both buffers one word per cycle before accepting the next operand.
module mont_result_collector
   import ecc_mont_pkg::*;
#(
   parameter int RADIX     = RADIX_DEF,
   parameter int NUM_WORDS = NUM_WORDS_DEF
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [RADIX*NUM_WORDS-1:0] p_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic [RADIX-1:0]           s_word_i,
   input  logic                       s_last_i,
   input  logic                       s_carry_i,
   output logic                       r_valid_o,
   input  logic                       r_ready_i,
   output logic [RADIX-1:0]           r_word_o,
   output logic                       r_last_o,
   output logic                       busy_o,
   output logic                       err_o
);

   localparam int               CNT_W    = $clog2(NUM_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   coll_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_rcnt;
   logic             r_borrow;
   logic             r_carry;
   logic             r_sel_d;
   logic             r_err;
   logic             r_s_ready;
   logic             r_busy;
   logic             r_out_vld;
   logic [RADIX-1:0] r_out_word;
   logic             r_out_last;
   logic [RADIX-1:0] r_sbuf [NUM_WORDS];
   logic [RADIX-1:0] r_dbuf [NUM_WORDS];

   logic [RADIX-1:0] w_p_word [NUM_WORDS];
   logic             w_acc;
   logic             w_cnt_last;
   logic             w_bin;
   logic [RADIX-1:0] w_diff;
   logic             w_bout;
   logic             w_sel;
   logic [RADIX-1:0] w_mask_dec;
   logic [RADIX-1:0] w_mask_drn;
   logic [CNT_W-1:0] w_nxt_idx;

   always_comb begin
      for (int k = 0; k < NUM_WORDS; k++) begin
         w_p_word[k] = p_i[k*RADIX +: RADIX];
      end
   end

   assign w_acc      = s_valid_i & r_s_ready;
   assign w_cnt_last = (r_cnt == LAST_IDX);
   // Borrow chain restarts at word 0 regardless of what the previous operand left.
   assign w_bin      = (r_cnt == '0) ? 1'b0 : r_borrow;
   // S >= p exactly when the top carry is set or S-p did not borrow out.
   assign w_sel      = r_carry | ~r_borrow;
   // Selection is a bit mask, so the drain timing never depends on the data.
   assign w_mask_dec = {RADIX{w_sel}};
   assign w_mask_drn = {RADIX{r_sel_d}};
   assign w_nxt_idx  = r_rcnt + 1'b1;

   word_sub_borrow #(.RADIX(RADIX)) u_sub (
      .i_a    (s_word_i),
      .i_b    (w_p_word[r_cnt]),
      .i_bin  (w_bin),
      .o_d    (w_diff),
      .o_bout (w_bout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_rcnt     <= '0;
         r_borrow   <= 1'b0;
         r_carry    <= 1'b0;
         r_sel_d    <= 1'b0;
         r_err      <= 1'b0;
         r_s_ready  <= 1'b1;
         r_busy     <= 1'b0;
         r_out_vld  <= 1'b0;
         r_out_word <= '0;
         r_out_last <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) begin
            r_sbuf[k] <= '0;
            r_dbuf[k] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE, ST_COLLECT: begin
               if (w_acc) begin
                  r_sbuf[r_cnt] <= s_word_i;
                  r_dbuf[r_cnt] <= w_diff;
                  r_borrow      <= w_bout;
                  r_busy        <= 1'b1;
                  // The word count alone frames the operand; s_last_i is only checked.
                  if (s_last_i != w_cnt_last) begin
                     r_err <= 1'b1;
                  end
                  if (w_cnt_last) begin
                     r_cnt     <= '0;
                     r_carry   <= s_carry_i;
                     r_s_ready <= 1'b0;
                     r_state   <= ST_DECIDE;
                  end else begin
                     r_cnt   <= r_cnt + 1'b1;
                     r_state <= ST_COLLECT;
                  end
               end
            end

            ST_DECIDE: begin
               r_sel_d    <= w_sel;
               r_rcnt     <= '0;
               r_out_vld  <= 1'b1;
               r_out_word <= (r_dbuf[0] & w_mask_dec) | (r_sbuf[0] & ~w_mask_dec);
               r_out_last <= 1'b0;
               r_state    <= ST_DRAIN;
            end

            ST_DRAIN: begin
               if (r_ready_i) begin
                  if (r_out_last) begin
                     r_out_vld  <= 1'b0;
                     r_out_last <= 1'b0;
                     r_out_word <= '0;
                     r_rcnt     <= '0;
`ifdef MONT_COLLECT_ZEROIZE_EN
                     r_state    <= ST_ZERO;
`else
                     r_state    <= ST_IDLE;
                     r_s_ready  <= 1'b1;
                     r_busy     <= 1'b0;
`endif
                  end else begin
                     r_rcnt     <= w_nxt_idx;
                     r_out_word <= (r_dbuf[w_nxt_idx] & w_mask_drn) |
                                   (r_sbuf[w_nxt_idx] & ~w_mask_drn);
                     r_out_last <= (w_nxt_idx == LAST_IDX);
                  end
               end
            end

`ifdef MONT_COLLECT_ZEROIZE_EN
            ST_ZERO: begin
               r_sbuf[r_rcnt] <= '0;
               r_dbuf[r_rcnt] <= '0;
               r_sel_d        <= 1'b0;
               r_borrow       <= 1'b0;
               if (r_rcnt == LAST_IDX) begin
                  r_rcnt    <= '0;
                  r_state   <= ST_IDLE;
                  r_s_ready <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_rcnt <= w_nxt_idx;
               end
            end
`endif

            default: begin
               r_state   <= ST_IDLE;
               r_s_ready <= 1'b1;
               r_busy    <= 1'b0;
               r_out_vld <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready_o = r_s_ready;
   assign r_valid_o = r_out_vld;
   assign r_word_o  = r_out_word;
   assign r_last_o  = r_out_last;
   assign busy_o    = r_busy;
   assign err_o     = r_err;

endmodule

// File: tb/tb_mont_result_collector.sv
// Self-checking bench for mont_result_collector (default build).
// Reference: whole-operand arithmetic on 385-bit vectors, (S >= p) ? S-p : S.
// Stimulus: directed corner operands followed by randomized operands with random stalls.
module tb_mont_result_collector;

   localparam int RADIX = 32;
   localparam int NW    = 12;
   localparam int W     = RADIX * NW;

   logic             clk;
   logic             reset_n;
   logic [W-1:0]     p_i;
   logic             s_valid_i;
   logic             s_ready_o;
   logic [RADIX-1:0] s_word_i;
   logic             s_last_i;
   logic             s_carry_i;
   logic             r_valid_o;
   logic             r_ready_i;
   logic [RADIX-1:0] r_word_o;
   logic             r_last_o;
   logic             busy_o;
   logic             err_o;

   int n_checks = 0;
   int n_errors = 0;

   mont_result_collector #(.RADIX(RADIX), .NUM_WORDS(NW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .p_i       (p_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .s_word_i  (s_word_i),
      .s_last_i  (s_last_i),
      .s_carry_i (s_carry_i),
      .r_valid_o (r_valid_o),
      .r_ready_i (r_ready_i),
      .r_word_o  (r_word_o),
      .r_last_o  (r_last_o),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reduced result straight from the definition of modular reduction.
   function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic c,
                                          input logic [W-1:0] p);
      logic [W:0] sf;
      logic [W:0] pf;
      logic [W:0] df;
      sf = {c, s};
      pf = {1'b0, p};
      df = sf - pf;
      if (sf >= pf) return df[W-1:0];
      return s;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int k = 0; k < NW; k++) v[k*RADIX +: RADIX] = $urandom();
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, r_valid_o, 0);
      chk({tag, "_ready"}, s_ready_o, 1);
      chk({tag, "_busy"},  busy_o, 0);
   endtask

   // Streams one operand; s_last_i is raised on word last_pos.
   // Afterwards checks the two-cycle turnaround to the first output word.
   task automatic send(input logic [W-1:0] s, input logic c, input int last_pos, input bit gaps);
      int  k;
      int  guard;
      bit  acc;
      k = 0;
      guard = 0;
      while (k < NW && guard < 400) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid_i = 1'b0;
         end else begin
            s_valid_i = 1'b1;
            s_word_i  = s[k*RADIX +: RADIX];
            s_last_i  = (k == last_pos);
            s_carry_i = (k == NW - 1) ? c : 1'($urandom_range(0, 1));
         end
         acc = s_valid_i && s_ready_o;
         tick();
         if (acc) k++;
         guard++;
      end
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_carry_i = 1'b0;
      chk("send_words_accepted", k, NW);
      chk("decide_valid_low", r_valid_o, 0);
      chk("decide_ready_low", s_ready_o, 0);
      chk("decide_busy", busy_o, 1);
      tick();
      chk("first_out_valid", r_valid_o, 1);
   endtask

   // mode 0: always ready, 1: ready toggles starting low, 2: random ready.
   // Returns after stop_at words have been handed over.
   task automatic drain(input logic [W-1:0] exp, input int mode, input int stop_at);
      int idx;
      int guard;
      bit rdy;
      idx = 0;
      guard = 0;
      while (idx < stop_at && guard < 400) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (guard % 2 == 1);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         r_ready_i = rdy;
         if (r_valid_o) begin
            chk("out_word", r_word_o, exp[idx*RADIX +: RADIX]);
            chk("out_last", r_last_o, (idx == NW - 1));
            if (rdy) idx++;
         end
         tick();
         guard++;
      end
      r_ready_i = 1'b0;
      chk("drain_words_seen", idx, stop_at);
   endtask

   initial begin
      logic [W-1:0] p;
      logic [W-1:0] s;
      logic         c;
      int           kind;

      reset_n   = 1'b0;
      p_i       = '0;
      s_valid_i = 1'b0;
      s_word_i  = '0;
      s_last_i  = 1'b0;
      s_carry_i = 1'b0;
      r_ready_i = 1'b0;

      // Reset values
      tick();
      tick();
      check_idle("rst");
      chk("rst_word", r_word_o, 0);
      chk("rst_last", r_last_o, 0);
      chk("rst_err", err_o, 0);
      reset_n = 1'b1;
      tick();

      // Modulus with top bits 01 so p+small and 2^384+3-p stay meaningful.
      p = rand_vec();
      p[W-1 -: 2] = 2'b01;
      p_i = p;

      // 1: S = p+5, no stalls -> 5,0,...,0
      s = p + W'(5);
      send(s, 1'b0, NW - 1, 1'b0);
      drain(model(s, 1'b0, p), 0, NW);
      check_idle("t1_end");
      chk("t1_err", err_o, 0);

      // 2: S = p-1 -> unchanged
      s = p - W'(1);
      send(s, 1'b0, NW - 1, 1'b0);
      drain(model(s, 1'b0, p), 0, NW);
      check_idle("t2_end");

      // 3: S = p -> zero
      s = p;
      send(s, 1'b0, NW - 1, 1'b1);
      drain(model(s, 1'b0, p), 0, NW);
      check_idle("t3_end");

      // 4: carry set, low words = 3, ready toggling
      s = W'(3);
      send(s, 1'b1, NW - 1, 1'b0);
      drain(model(s, 1'b1, p), 1, NW);
      check_idle("t4_end");
      chk("t4_err", err_o, 0);

      // 5: s_last_i on word 5 -> sticky error, operand still runs full length
      s = rand_vec();
      send(s, 1'b0, 5, 1'b1);
      chk("t5_err_set", err_o, 1);
      drain(model(s, 1'b0, p), 2, NW);
      check_idle("t5_end");
      chk("t5_err_sticky", err_o, 1);

      // 6: reset pulse during drain word 4
      s = rand_vec();
      c = 1'($urandom_range(0, 1));
      send(s, c, NW - 1, 1'b0);
      drain(model(s, c, p), 0, 4);
      chk("t6_pre_valid", r_valid_o, 1);
      reset_n = 1'b0;
      #1;
      check_idle("t6_rst");
      chk("t6_rst_word", r_word_o, 0);
      chk("t6_rst_last", r_last_o, 0);
      chk("t6_rst_err", err_o, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check_idle("t6_after");

      // Randomized operands against the reference model.
      for (int n = 0; n < 10; n++) begin
         if (n % 3 == 0) begin
            p = rand_vec();
            p[W-1 -: 2] = 2'b01;
            p_i = p;
         end
         kind = $urandom_range(0, 3);
         case (kind)
            0:       begin s = rand_vec(); c = 1'($urandom_range(0, 1)); end
            1:       begin s = p - W'($urandom_range(0, 1000)); c = 1'b0; end
            2:       begin s = p + W'($urandom_range(0, 1000)); c = 1'b0; end
            default: begin s = rand_vec(); s[W-1] = 1'b0; c = 1'b1; end
         endcase
         send(s, c, NW - 1, 1'b1);
         drain(model(s, c, p), 2, NW);
         check_idle("rnd_end");
      end
      chk("rnd_err", err_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
